// File: rtl/thermo_code_generator_pkg.sv
// Shared definitions for the TDC thermometer stimulus generator: FSM encoding
// and default geometry of the delay line.
package thermo_code_generator_pkg;

  localparam int TDC_TAPS   = 16;
  localparam int TDC_BIN_W  = 4;
  localparam int TDC_HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/thermo_code_generator_bin_to_thermo.sv
// Combinational binary-to-thermometer mapping: bits k..WIDTH-1 set, with codes
// beyond the last tap saturating to the last tap.
module bin_to_thermo #(
  parameter int WIDTH = 16,
  parameter int BIN_W = 4
) (
  input  logic [BIN_W-1:0] bin,
  output logic [WIDTH-1:0] thermo
);

  localparam logic [BIN_W:0]   WIDTH_C = (BIN_W+1)'(WIDTH);
  localparam logic [BIN_W-1:0] LAST_C  = BIN_W'(WIDTH - 1);

  logic [BIN_W-1:0] k_s;

  // Saturate the code, then shift an all-ones word up by it.
  always_comb begin
    if ({1'b0, bin} >= WIDTH_C) begin
      k_s = LAST_C;
    end else begin
      k_s = bin;
    end
    thermo = {WIDTH{1'b1}} << k_s;
  end

endmodule

// File: rtl/thermo_code_generator.sv
// TDC self-test stimulus: single-shot code conversion over valid/ready, or an
// autonomous 0..WIDTH-1 sweep with a programmable per-code hold time.
module thermo_code_generator
  import thermo_code_generator_pkg::*;
#(
  parameter int WIDTH  = TDC_TAPS,
  parameter int BIN_W  = TDC_BIN_W,
  parameter int HOLD_W = TDC_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode_sweep,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              bin_valid,
  output logic              bin_ready,
  output logic [WIDTH-1:0]  thermo,
  output logic [BIN_W-1:0]  code_out,
  output logic              thermo_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [BIN_W-1:0] LAST_CODE = BIN_W'(WIDTH - 1);

  state_e            state_r, state_s;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [BIN_W-1:0]  code_r, code_s;
  logic [WIDTH-1:0]  thermo_r, word_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              ready_s, handshake_s, start_sweep_s, hold_zero_s;

  assign ready_s       = enable & (state_r == ST_IDLE) & ~start;
  assign handshake_s   = bin_valid & ready_s;
  assign start_sweep_s = enable & start & mode_sweep & (state_r == ST_IDLE);
  assign hold_zero_s   = (hold_cnt_r == {HOLD_W{1'b0}});

  bin_to_thermo #(
    .WIDTH (WIDTH),
    .BIN_W (BIN_W)
  ) u_map (
    .bin    (code_s),
    .thermo (word_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; dropping enable always returns to IDLE.
  always_comb begin
    state_s = state_r;
    if (!enable) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_sweep_s) begin
            state_s = ST_SWEEP;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SWEEP: begin
          if (hold_zero_s && (code_r == LAST_CODE)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_SWEEP;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values: code, hold counter and strobes.
  always_comb begin
    code_s     = code_r;
    hold_s     = hold_r;
    hold_cnt_s = hold_cnt_r;
    valid_s    = 1'b0;
    busy_s     = (state_s == ST_SWEEP);
    done_s     = (state_s == ST_DONE);
    if (!enable) begin
      code_s     = {BIN_W{1'b0}};
      hold_cnt_s = {HOLD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_sweep_s) begin
            hold_s     = hold_cycles;
            hold_cnt_s = hold_cycles;
            code_s     = {BIN_W{1'b0}};
            valid_s    = 1'b1;
          end else if (handshake_s) begin
            code_s  = bin_in;
            valid_s = 1'b1;
          end else begin
            valid_s = 1'b0;
          end
        end
        ST_SWEEP: begin
          if (!hold_zero_s) begin
            hold_cnt_s = hold_cnt_r - HOLD_W'(1);
          end else if (code_r != LAST_CODE) begin
            code_s     = code_r + BIN_W'(1);
            hold_cnt_s = hold_r;
            valid_s    = 1'b1;
          end else begin
            valid_s = 1'b0;
          end
        end
        ST_DONE: valid_s = 1'b0;
        default: valid_s = 1'b0;
      endcase
    end
  end

  // Output and counter registers; thermo only changes alongside a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r     <= {HOLD_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
      code_r     <= {BIN_W{1'b0}};
      thermo_r   <= {WIDTH{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      hold_r     <= hold_s;
      hold_cnt_r <= hold_cnt_s;
      code_r     <= code_s;
      valid_r    <= valid_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      if (!enable) begin
        thermo_r <= {WIDTH{1'b0}};
      end else if (valid_s) begin
        thermo_r <= word_s;
      end else begin
        thermo_r <= thermo_r;
      end
    end
  end

  assign bin_ready    = ready_s;
  assign thermo       = thermo_r;
  assign code_out     = code_r;
  assign thermo_valid = valid_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_thermo_code_generator.sv
// Scoreboard bench for thermo_code_generator: stimulus pushes expected strobes,
// a negedge monitor pops and compares them, including cycle timing.
module tb_thermo_code_generator;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] word;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode_sweep = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  hold_cycles = 8'd0;
  logic [3:0]  bin_in = 4'd0;
  logic        bin_valid = 1'b0;
  logic        bin_ready;
  logic [15:0] thermo;
  logic [3:0]  code_out;
  logic        thermo_valid;
  logic        busy;
  logic        done;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  exp_t exp_q[$];
  int   done_q[$];

  thermo_code_generator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mode_sweep   (mode_sweep),
    .start        (start),
    .hold_cycles  (hold_cycles),
    .bin_in       (bin_in),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .thermo       (thermo),
    .code_out     (code_out),
    .thermo_valid (thermo_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] therm_of(int k);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = (i >= k);
    return t;
  endfunction

  // Stand-in for the TDC thermometer encoder: index of the lowest set bit.
  function automatic int encode(logic [15:0] t);
    for (int i = 0; i < 16; i++) begin
      if (t[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_sweep(int c, int h, int ncodes);
    for (int k = 0; k < ncodes; k++) begin
      exp_q.push_back('{code: 4'(k), word: therm_of(k), cyc: c + 1 + k * (h + 1)});
    end
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 400) begin
      step();
      n++;
    end
    check({name, "_drain_timeout"}, n < 400 ? 1 : 0, 1);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (thermo_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: code_out=%0d thermo=0x%0h cyc=%0d", code_out, thermo, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_code", int'(code_out), int'(e.code));
        check("strobe_thermo", int'(thermo), int'(e.word));
        check("strobe_cycle", cyc, e.cyc);
      end
      check("loopback_encoder", encode(thermo), int'(code_out));
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: cyc=%0d", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
      end
    end
    if (busy) busy_cnt++;
  end

  initial begin
    int c;
    int n;

    // Reset and release.
    repeat (3) step();
    check("rst_thermo", int'(thermo), 0);
    check("rst_code", int'(code_out), 0);
    check("rst_flags", int'({thermo_valid, busy, done}), 0);
    check("ready_when_disabled", int'(bin_ready), 0);
    rst_n = 1'b1;
    step();
    enable = 1'b1;
    #1;
    check("ready_after_enable", int'(bin_ready), 1);
    step();

    // Single-shot back-to-back: 5, 0, 15.
    bin_valid = 1'b1;
    bin_in = 4'd5;
    exp_q.push_back('{code: 4'd5, word: 16'hFFE0, cyc: cyc + 1});
    step();
    bin_in = 4'd0;
    exp_q.push_back('{code: 4'd0, word: 16'hFFFF, cyc: cyc + 1});
    step();
    bin_in = 4'd15;
    exp_q.push_back('{code: 4'd15, word: 16'h8000, cyc: cyc + 1});
    step();
    bin_valid = 1'b0;
    repeat (4) step();
    check("single_hold_thermo", int'(thermo), 32'h8000);
    check("single_queue_empty", exp_q.size(), 0);

    // start without mode_sweep: ignored, bin_ready drops while start is high.
    start = 1'b1;
    mode_sweep = 1'b0;
    #1;
    check("ready_low_on_start", int'(bin_ready), 0);
    step();
    start = 1'b0;
    repeat (3) step();
    check("no_sweep_busy", int'(busy), 0);

    // Sweep with H=2.
    busy_cnt = 0;
    start = 1'b1;
    mode_sweep = 1'b1;
    hold_cycles = 8'd2;
    c = cyc;
    push_sweep(c, 2, 16);
    done_q.push_back(c + 49);
    step();
    start = 1'b0;
    hold_cycles = 8'd0;
    drain("sweep_h2");
    step();
    check("sweep_h2_busy_cycles", busy_cnt, 48);
    check("sweep_h2_last_thermo", int'(thermo), 32'h8000);

    // start together with bin_valid: sweep (H=0) wins, bin_in not loaded.
    busy_cnt = 0;
    start = 1'b1;
    bin_valid = 1'b1;
    bin_in = 4'd9;
    hold_cycles = 8'd0;
    #1;
    check("ready_low_start_and_valid", int'(bin_ready), 0);
    c = cyc;
    push_sweep(c, 0, 16);
    done_q.push_back(c + 17);
    step();
    start = 1'b0;
    bin_valid = 1'b0;
    drain("sweep_h0");
    step();
    check("sweep_h0_busy_cycles", busy_cnt, 16);

    // Abort at code 7 (H=1) by dropping enable; no done expected.
    start = 1'b1;
    hold_cycles = 8'd1;
    c = cyc;
    push_sweep(c, 1, 8);
    step();
    start = 1'b0;
    n = 0;
    while (cyc < c + 15 && n < 100) begin
      step();
      n++;
    end
    enable = 1'b0;
    step();
    check("abort_thermo", int'(thermo), 0);
    check("abort_code", int'(code_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_queue_empty", exp_q.size(), 0);
    enable = 1'b1;
    repeat (3) step();
    check("abort_no_done", int'(done), 0);

    // Restart after abort begins again at code 0.
    start = 1'b1;
    hold_cycles = 8'd0;
    c = cyc;
    push_sweep(c, 0, 16);
    done_q.push_back(c + 17);
    step();
    start = 1'b0;
    drain("restart");

    // Asynchronous reset mid-sweep (H=3): codes 0 and 1 appear before it.
    step();
    start = 1'b1;
    hold_cycles = 8'd3;
    c = cyc;
    push_sweep(c, 3, 2);
    step();
    start = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    check("async_rst_thermo", int'(thermo), 0);
    check("async_rst_code", int'(code_out), 0);
    check("async_rst_flags", int'({thermo_valid, busy, done}), 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("final_exp_queue", exp_q.size(), 0);
    check("final_done_queue", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
